// File: rtl/axis_irq_rsp_arb_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_irq_rsp_arb_if                                           |
// | Description : Bundle of the IRQ response arbiter handshake signals: the     |
// |               NUM_SRC source-side AXI-Stream lanes and the single merged    |
// |               sink-side stream with its source index.                       |
// |   s_tvalid [NUM_SRC]              per-source valid                          |
// |   s_tdata  [NUM_SRC*TDATA_WIDTH]  per-source beat, source i at i*DW         |
// |   s_tready [NUM_SRC]              per-source ready (one-hot or zero)        |
// |   m_tvalid / m_tdata / m_tsrc     merged output beat and its source index   |
// |   m_tready                        sink ready                                |
// |   Modport slave  : the arbiter's view (consumes sources, drives the sink).  |
// |   Modport master : the environment's view (drives sources, is the sink).    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface axis_irq_rsp_arb_if #(
  parameter int NUM_SRC     = 4,
  parameter int TDATA_WIDTH = 32
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]             s_tvalid;
  logic [NUM_SRC*TDATA_WIDTH-1:0] s_tdata;
  logic [NUM_SRC-1:0]             s_tready;
  logic                           m_tvalid;
  logic [TDATA_WIDTH-1:0]         m_tdata;
  logic [SRC_W-1:0]               m_tsrc;
  logic                           m_tready;

  modport slave (
    input  s_tvalid,
    input  s_tdata,
    output s_tready,
    output m_tvalid,
    output m_tdata,
    output m_tsrc,
    input  m_tready
  );

  modport master (
    output s_tvalid,
    output s_tdata,
    input  s_tready,
    input  m_tvalid,
    input  m_tdata,
    input  m_tsrc,
    output m_tready
  );
endinterface
`default_nettype wire

// File: rtl/axis_irq_rsp_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_irq_rsp_arb                                              |
// | Description : Per-beat round-robin arbiter merging NUM_SRC single-beat      |
// |               AXI-Stream IRQ response sources onto one registered output    |
// |               stream. Reports the source index of each beat and keeps a    |
// |               saturating count of beats accepted by the sink.               |
// | Ports       :                                                               |
// |   clk      in   block clock shared by all sources and the sink             |
// |   rst      in   asynchronous active-high reset                              |
// |   bus      if   handshake bundle (slave modport), see axis_irq_rsp_arb_if   |
// |   fwd_cnt  out  saturating count of sink handshakes                         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module axis_irq_rsp_arb #(
  parameter int NUM_SRC     = 4,
  parameter int TDATA_WIDTH = 32,   // IRQ response beat width
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  axis_irq_rsp_arb_if.slave  bus,
  output logic [CNT_W-1:0]   fwd_cnt
);

  localparam int SRC_W = $clog2(NUM_SRC);
  // One extra bit so rr_ptr + offset never overflows before the modulo fold.
  localparam int IDX_W = SRC_W + 1;
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

  // Registered state
  logic                   m_tvalid_q;
  logic [TDATA_WIDTH-1:0] m_tdata_q;
  logic [SRC_W-1:0]       m_tsrc_q;
  logic [SRC_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       cnt_q;

  // Combinational arbitration results
  logic                   load_en;
  logic                   any_valid;
  logic [SRC_W-1:0]       grant;
  logic [IDX_W-1:0]       cand;
  logic [SRC_W-1:0]       nxt_ptr;
  logic [NUM_SRC-1:0]     ready;
  logic [TDATA_WIDTH-1:0] sel_data;
  logic                   take;
  logic                   sink_hs;

  // The output register can accept a new beat when empty or being drained.
  assign load_en = ~m_tvalid_q | bus.m_tready;

  // Search from rr_ptr upward, folding indices back into 0..NUM_SRC-1 so a
  // non-power-of-2 source count never produces an out-of-range candidate.
  always_comb begin
    any_valid = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = IDX_W'(rr_ptr) + IDX_W'(k);
      if (cand >= IDX_W'(NUM_SRC)) begin
        cand = cand - IDX_W'(NUM_SRC);
      end
      if (!any_valid && bus.s_tvalid[cand[SRC_W-1:0]]) begin
        any_valid = 1'b1;
        grant     = cand[SRC_W-1:0];
      end
    end
  end

  // Ready is forced low while reset is asserted even though the output
  // register already reads empty, so no source sees a spurious handshake.
  always_comb begin
    ready = '0;
    if (load_en && any_valid && !rst) begin
      ready[grant] = 1'b1;
    end
  end

  assign bus.s_tready = ready;
  assign take         = load_en & any_valid;
  assign sink_hs      = m_tvalid_q & bus.m_tready;
  assign nxt_ptr      = (grant == LAST_SRC) ? '0 : grant + 1'b1;

  // Data mux of the granted lane; only loaded into the register on a take.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant == SRC_W'(k)) begin
        sel_data = bus.s_tdata[k*TDATA_WIDTH +: TDATA_WIDTH];
      end
    end
  end

  // Output register stage and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tsrc_q   <= '0;
      rr_ptr     <= '0;
    end else if (load_en) begin
      if (take) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= sel_data;
        m_tsrc_q   <= grant;
        rr_ptr     <= nxt_ptr;
      end else begin
        // Nothing to forward: drop valid, data and index are don't-care.
        m_tvalid_q <= 1'b0;
      end
    end
  end

  // Saturating forwarded-beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (sink_hs && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tsrc   = m_tsrc_q;
  assign fwd_cnt      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_irq_rsp_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axis_irq_rsp_arb                                           |
// | Description : Self-checking bench for axis_irq_rsp_arb (4 sources, 16-bit  |
// |               beats, 4-bit counter) against a behavioural model: an output |
// |               slot, a modulo round-robin pointer and a saturating count.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_axis_irq_rsp_arb;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] fwd_cnt;

  axis_irq_rsp_arb_if #(.NUM_SRC(N), .TDATA_WIDTH(DW)) bus ();

  axis_irq_rsp_arb #(.NUM_SRC(N), .TDATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .fwd_cnt (fwd_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Source stimulus state
  logic [N-1:0]  sv;
  logic [DW-1:0] sd [N];

  always_comb begin
    bus.s_tvalid = sv;
    bus.s_tdata  = '0;
    for (int i = 0; i < N; i++) bus.s_tdata[i*DW +: DW] = sd[i];
  end

  // Reference model state
  int            m_ptr;
  bit            m_v;
  logic [DW-1:0] m_d;
  int            m_s;
  int            m_cnt;
  int            last_g;
  bit            last_hs;
  logic [DW-1:0] held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_v = 0; m_d = '0; m_s = 0; m_cnt = 0; last_hs = 0; last_g = -1;
  endtask

  // One clock: check outputs against the model before the edge, then advance
  // the model with the handshakes the spec rules say happen on that edge.
  task automatic cycle();
    int g;
    bit load;
    logic [N-1:0] er;
    #1;
    g    = pick(sv, m_ptr);
    load = !m_v || bus.m_tready;
    er   = '0;
    if (load && g >= 0) er[g] = 1'b1;
    check("s_tready", 32'(bus.s_tready), 32'(er));
    check("m_tvalid", 32'(bus.m_tvalid), 32'(m_v));
    if (m_v) begin
      check("m_tdata", 32'(bus.m_tdata), 32'(m_d));
      check("m_tsrc", 32'(bus.m_tsrc), m_s);
    end
    check("fwd_cnt", 32'(fwd_cnt), m_cnt);
    @(posedge clk);
    if (m_v && bus.m_tready && m_cnt < CMAX) m_cnt++;
    last_hs = load && (g >= 0);
    last_g  = g;
    if (load) begin
      if (g >= 0) begin
        m_v = 1; m_d = sd[g]; m_s = g; m_ptr = (g + 1) % N;
      end else begin
        m_v = 0;
      end
    end
    @(negedge clk);
  endtask

  // AXI-S sources: a lane only changes once idle or just accepted.
  task automatic refresh(input int pct);
    for (int i = 0; i < N; i++) begin
      if (!sv[i] || (last_hs && last_g == i)) begin
        sv[i] = ($urandom_range(99) < pct);
        sd[i] = DW'($urandom);
      end
    end
  endtask

  task automatic new_data_for_last();
    if (last_hs) sd[last_g] = DW'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    sv = '1;
    for (int i = 0; i < N; i++) sd[i] = DW'($urandom);
    bus.m_tready = 1'b1;
    model_reset();

    // Reset with all sources requesting
    repeat (2) @(negedge clk);
    #1;
    check("rst_s_tready", 32'(bus.s_tready), 32'h0);
    check("rst_m_tvalid", 32'(bus.m_tvalid), 32'h0);
    check("rst_fwd_cnt", 32'(fwd_cnt), 32'h0);
    check("rst_m_tdata", 32'(bus.m_tdata), 32'h0);
    check("rst_m_tsrc", 32'(bus.m_tsrc), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Full-rate round robin, 13 edges deliver 12 sink handshakes
    for (int k = 0; k < 13; k++) begin
      cycle();
      refresh(100);
      check("rr_order_src", 32'(bus.m_tsrc), k % N);
    end
    check("rr_fwd_cnt12", 32'(fwd_cnt), 32'd12);

    // Sparse requests with wrap: move rr_ptr to 2 via source 1
    do_reset();
    sv = 4'b0010;
    cycle();
    new_data_for_last();
    sv = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("sparse_grant", 32'(bus.s_tready), (k % 2 == 0) ? 32'h8 : 32'h2);
      cycle();
      new_data_for_last();
    end
    sv = 4'b0001;
    #1;
    check("src0_grant", 32'(bus.s_tready), 32'h1);
    cycle();
    new_data_for_last();
    sv = 4'b1111;
    #1;
    check("ptr_after_src0", 32'(bus.s_tready), 32'h2);
    cycle();
    new_data_for_last();

    // Backpressure: hold the loaded beat for 5 cycles
    bus.m_tready = 1'b0;
    held = m_d;
    for (int k = 0; k < 5; k++) begin
      cycle();
      refresh(70);
      check("bp_hold_data", 32'(bus.m_tdata), 32'(held));
    end
    sv = 4'b1111;
    bus.m_tready = 1'b1;
    #1;
    check("bp_release_ready", 32'(|bus.s_tready), 32'h1);
    cycle();
    refresh(100);

    // Counter saturation
    for (int k = 0; k < 20; k++) begin
      cycle();
      refresh(100);
    end
    check("cnt_saturated", 32'(fwd_cnt), 32'd15);

    // Random traffic with random sink backpressure
    do_reset();
    for (int k = 0; k < 150; k++) begin
      bus.m_tready = ($urandom_range(99) < 60);
      cycle();
      refresh(50);
    end

    // Asynchronous reset between edges with a beat in flight
    bus.m_tready = 1'b0;
    sv = 4'b1111;
    cycle();
    check("pre_arst_valid", 32'(bus.m_tvalid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_m_tvalid", 32'(bus.m_tvalid), 32'h0);
    check("arst_s_tready", 32'(bus.s_tready), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.m_tready = 1'b1;
    #1;
    check("arst_ptr0", 32'(bus.s_tready), 32'h1);
    cycle();
    refresh(100);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
